// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory arbiter slice.
// Provides lc3b_word, lc3b_cline, the arbiter state enum and grant bundle.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cline;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_L2 = 2'd1,
        GRANT_PF = 2'd2
    } pmem_arb_state_t;

    // One-hot grant: at most one field set, none in IDLE.
    typedef struct packed {
        logic pf;
        logic l2;
    } pmem_grant_t;

endpackage

// File: rtl/pmem_arbiter_fsm.sv
// Arbiter FSM: state register, next-state logic and starvation counter.
// Ports: clk, rst_n, dreq_i, pf_req_i, pmem_resp_i in; grant_o one-hot out.
module pmem_arbiter_fsm
    import lc3b_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dreq_i,
    input  logic        pf_req_i,
    input  logic        pmem_resp_i,
    output pmem_grant_t grant_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    pmem_arb_state_t state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_o = '0;
        unique case (state_q)
            IDLE: begin
                // Prefetcher withdrew: its wait history no longer matters.
                if (!pf_req_i)
                    cnt_d = '0;
                if (pf_req_i && cnt_q == LIMIT) begin
                    state_d = GRANT_PF;
                    cnt_d   = '0;
                end else if (dreq_i) begin
                    state_d = GRANT_L2;
                    if (pf_req_i)
                        cnt_d = cnt_q + 4'd1;
                end else if (pf_req_i) begin
                    state_d = GRANT_PF;
                    cnt_d   = '0;
                end
            end
            GRANT_L2: begin
                grant_o.l2 = 1'b1;
                if (pmem_resp_i)
                    state_d = IDLE;
            end
            GRANT_PF: begin
                grant_o.pf = 1'b1;
                if (pmem_resp_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares the pmem port between L2 demand traffic and the prefetcher.
// Ports: l2_* and pf_* requester sides, pmem_* memory side, clk/rst_n.
module pmem_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      l2_pmem_read,
    input  logic      l2_pmem_write,
    input  lc3b_word  l2_pmem_address,
    input  lc3b_cline l2_pmem_wdata,
    output lc3b_cline l2_pmem_rdata,
    output logic      l2_pmem_resp,
    input  logic      pf_pmem_read,
    input  lc3b_word  pf_pmem_address,
    output lc3b_cline pf_pmem_rdata,
    output logic      pf_pmem_resp,
    output logic      pmem_read,
    output logic      pmem_write,
    output lc3b_word  pmem_address,
    output lc3b_cline pmem_wdata,
    input  lc3b_cline pmem_rdata,
    input  logic      pmem_resp
);

    pmem_grant_t grant;

    pmem_arbiter_fsm #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .dreq_i      (l2_pmem_read | l2_pmem_write),
        .pf_req_i    (pf_pmem_read),
        .pmem_resp_i (pmem_resp),
        .grant_o     (grant)
    );

    // Read data is broadcast; only resp tells a requester it is valid.
    assign l2_pmem_rdata = pmem_rdata;
    assign pf_pmem_rdata = pmem_rdata;

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        l2_pmem_resp = 1'b0;
        pf_pmem_resp = 1'b0;
        unique case (1'b1)
            grant.l2: begin
                pmem_read    = l2_pmem_read;
                pmem_write   = l2_pmem_write;
                pmem_address = l2_pmem_address;
                pmem_wdata   = l2_pmem_wdata;
                l2_pmem_resp = pmem_resp;
            end
            grant.pf: begin
                pmem_read    = pf_pmem_read;
                pmem_address = pf_pmem_address;
                pf_pmem_resp = pmem_resp;
            end
            default: ;
        endcase
    end

endmodule
